// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types for the decode-stage hazard scoreboard.
// Shadow entry layout, forwarding select codes, select helper.
package id_hazard_scoreboard_pkg;

    localparam int SB_REG_W = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef struct packed {
        logic                v;
        logic [SB_REG_W-1:0] dest;
        logic                ld;
    } sb_entry_t;

    // A load in EXE has no result yet, so only a non-load EXE hit forwards.
    function automatic logic [1:0] fwd_pick(
        input logic e_hit,
        input logic e_ld,
        input logic m_hit
    );
        if (e_hit && !e_ld) return FWD_EXE;
        if (m_hit) return FWD_MEM;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_match.sv
// Compares one shadow entry against the two ID source indices.
// Purely combinational; one copy per pipeline stage.
module sb_entry_match
    import id_hazard_scoreboard_pkg::*;
(
    input  sb_entry_t           entry,
    input  logic [SB_REG_W-1:0] src1,
    input  logic [SB_REG_W-1:0] src2,
    input  logic                two_src,
    output logic                match1,
    output logic                match2
);

    logic unused_ld;

    assign unused_ld = entry.ld;

    assign match1 = entry.v & (entry.dest == src1);
    assign match2 = entry.v & two_src & (entry.dest == src2);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode hazard scoreboard: EXE/MEM/WB shadow of pending writes.
// Optional forwarding mode under `ID_HAZARD_FWD_EN.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = SB_REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             freeze,
    input  logic             flush,
    output logic             hazard,
`ifdef ID_HAZARD_FWD_EN
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
`endif
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sb_entry_t  e_q, m_q, w_q;
    logic [2:0] m1, m2;
    logic       alloc;
    logic       unused_bits;

    sb_entry_match u_match_e (
        .entry(e_q), .src1(id_src1), .src2(id_src2),
        .two_src(id_two_src), .match1(m1[0]), .match2(m2[0])
    );

    sb_entry_match u_match_m (
        .entry(m_q), .src1(id_src1), .src2(id_src2),
        .two_src(id_two_src), .match1(m1[1]), .match2(m2[1])
    );

    sb_entry_match u_match_w (
        .entry(w_q), .src1(id_src1), .src2(id_src2),
        .two_src(id_two_src), .match1(m1[2]), .match2(m2[2])
    );

`ifdef ID_HAZARD_FWD_EN
    // Only a load still in EXE cannot be bypassed.
    assign hazard = id_valid & ~flush & e_q.ld & (m1[0] | m2[0]);

    // Youngest producer wins; WB hits read the write-through register file.
    assign fwd_sel1 = id_valid ? fwd_pick(m1[0], e_q.ld, m1[1]) : FWD_RF;
    assign fwd_sel2 = id_valid ? fwd_pick(m2[0], e_q.ld, m2[1]) : FWD_RF;

    assign unused_bits = ^{w_q.ld, m1[2], m2[2]};
`else
    // Full interlock: any pending write to a read register stalls.
    assign hazard = id_valid & ~flush & ((|m1) | (|m2));

    assign unused_bits = w_q.ld;
`endif

    assign alloc = id_valid & id_wb_en & ~hazard & ~flush;

    // Shadow shift; a stalled, flushed or non-writing slot enters as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!freeze) begin
            w_q <= m_q;
            m_q <= e_q;
            if (alloc) begin
                e_q <= '{v: 1'b1, dest: id_dest, ld: id_mem_r_en};
            end else begin
                e_q <= '0;
            end
        end
    end

    // Saturating count of cycles actually lost to hazards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!freeze && hazard && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard.
// A narrow-counter copy shares the stimulus to reach saturation.
module tb_id_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_wb_en, id_mem_r_en;
    logic [3:0] id_dest, id_src1, id_src2;
    logic       id_two_src, freeze, flush;
    logic       hazard, hazard_s;
    logic [15:0] stall_cnt;
    logic [3:0]  small_cnt;
`ifdef ID_HAZARD_FWD_EN
    logic [1:0] fwd_sel1, fwd_sel2, fwd1_s, fwd2_s;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int pend = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .freeze(freeze),
        .flush(flush), .hazard(hazard),
`ifdef ID_HAZARD_FWD_EN
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
`endif
        .stall_cnt(stall_cnt)
    );

    id_hazard_scoreboard #(.REG_W(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .freeze(freeze),
        .flush(flush), .hazard(hazard_s),
`ifdef ID_HAZARD_FWD_EN
        .fwd_sel1(fwd1_s), .fwd_sel2(fwd2_s),
`endif
        .stall_cnt(small_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wb, input logic ld,
                         input logic [3:0] d, input logic [3:0] s1,
                         input logic [3:0] s2, input logic two,
                         input logic frz, input logic fl);
        id_valid = v; id_wb_en = wb; id_mem_r_en = ld;
        id_dest = d; id_src1 = s1; id_src2 = s2;
        id_two_src = two; freeze = frz; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic prod(input logic [3:0] d, input logic ld);
        drive(1'b1, 1'b1, ld, d, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cons(input logic [3:0] s1, input logic [3:0] s2,
                        input logic two);
        drive(1'b1, 1'b0, 1'b0, 4'd0, s1, s2, two, 1'b0, 1'b0);
    endtask

    // Check hazard mid-cycle; an expected unfrozen stall is counted.
    task automatic hz(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, {31'd0, hazard}, {31'd0, exp});
        chk({tag, "_s"}, {31'd0, hazard_s}, {31'd0, exp});
        if (exp && !freeze) pend = 1;
    endtask

    task automatic nxt();
        @(posedge clk);
        exp_cnt += pend;
        pend = 0;
        #1;
    endtask

    function automatic logic [31:0] sat4(input int c);
        return (c > 15) ? 32'd15 : c;
    endfunction

    task automatic chk_cnt(input string tag);
        chk(tag, {16'd0, stall_cnt}, exp_cnt);
        chk({tag, "_s"}, {28'd0, small_cnt}, sat4(exp_cnt));
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_hz", {31'd0, hazard}, 32'd0);
        chk_cnt("rst_cnt");
`ifdef ID_HAZARD_FWD_EN
        chk("rst_f1", {30'd0, fwd_sel1}, 32'd0);
        chk("rst_f2", {30'd0, fwd_sel2}, 32'd0);
`endif
        rst = 1'b1;
        nxt();

        // Async reset drops a live entry and the counter at once
        prod(4'd3, 1'b0); hz("p3", 1'b0); nxt();
        cons(4'd3, 4'd0, 1'b0); hz("c3a", 1'b1); nxt();
`ifdef ID_HAZARD_FWD_EN
        hz("c3b", 1'b0);
        chk_cnt("c3b_cnt");
        prod(4'd3, 1'b1); nxt();
        cons(4'd3, 4'd0, 1'b0); hz("c3c", 1'b1);
`else
        hz("c3b", 1'b1);
        chk_cnt("c3b_cnt");
`endif
        #1 rst = 1'b0;
        #1;
        chk("arst_hz", {31'd0, hazard}, 32'd0);
        pend = 0;
        exp_cnt = 0;
        chk_cnt("arst_cnt");
        nxt();
        idle();
        @(negedge clk);
        rst = 1'b1;
        nxt();
        cons(4'd3, 4'd0, 1'b0); hz("post_rst", 1'b0); nxt();

`ifdef ID_HAZARD_FWD_EN
        // Load-use: one stall, then MEM forward
        prod(4'd4, 1'b1); hz("ld_p", 1'b0); nxt();
        cons(4'd4, 4'd0, 1'b0); hz("ld_use", 1'b1); nxt();
        hz("ld_go", 1'b0);
        chk("ld_f1", {30'd0, fwd_sel1}, 32'd2);
        nxt();
        // ALU producer: EXE, then MEM, then RF
        prod(4'd4, 1'b0); nxt();
        cons(4'd4, 4'd0, 1'b0); hz("alu_e", 1'b0);
        chk("alu_f1e", {30'd0, fwd_sel1}, 32'd1);
        nxt();
        hz("alu_m", 1'b0);
        chk("alu_f1m", {30'd0, fwd_sel1}, 32'd2);
        nxt();
        hz("alu_w", 1'b0);
        chk("alu_f1w", {30'd0, fwd_sel1}, 32'd0);
        nxt();
        // Second operand paths
        prod(4'd6, 1'b0); nxt();
        cons(4'd1, 4'd6, 1'b1); hz("s2_hz", 1'b0);
        chk("s2_f2", {30'd0, fwd_sel2}, 32'd1);
        chk("s2_f1", {30'd0, fwd_sel1}, 32'd0);
        nxt();
        prod(4'd7, 1'b0); nxt();
        cons(4'd1, 4'd7, 1'b0); @(negedge clk);
        chk("imm_f2", {30'd0, fwd_sel2}, 32'd0);
        nxt();
        prod(4'd8, 1'b0); nxt();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("inv_f1", {30'd0, fwd_sel1}, 32'd0);
        nxt();
        // Youngest producer wins
        prod(4'd9, 1'b0); nxt();
        prod(4'd9, 1'b0); nxt();
        cons(4'd9, 4'd0, 1'b0); @(negedge clk);
        chk("young_f1", {30'd0, fwd_sel1}, 32'd1);
        nxt();
        // Load-use through src2
        prod(4'd5, 1'b1); nxt();
        cons(4'd1, 4'd5, 1'b1); hz("ld2_use", 1'b1); nxt();
        hz("ld2_go", 1'b0);
        chk("ld2_f2", {30'd0, fwd_sel2}, 32'd2);
        nxt();
        // Flush beats load-use
        prod(4'd11, 1'b1); nxt();
        drive(1'b1, 1'b1, 1'b0, 4'd12, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1);
        hz("fl_hz", 1'b0); nxt();
        chk_cnt("mid_cnt");
        // Saturation
        for (int i = 0; i < 16; i++) begin
            prod(4'd10, 1'b1); hz("sat_p", 1'b0); nxt();
            cons(4'd10, 4'd0, 1'b0); hz("sat_c", 1'b1); nxt();
        end
        idle(); @(negedge clk);
        chk_cnt("sat_cnt");
`else
        // RAW chain through src1: three stalls
        prod(4'd2, 1'b0); hz("raw_p", 1'b0); nxt();
        cons(4'd2, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            hz("raw_s", 1'b1); nxt();
        end
        hz("raw_go", 1'b0);
        chk_cnt("raw_cnt");
        nxt();
        // RAW through src2
        prod(4'd6, 1'b0); nxt();
        cons(4'd1, 4'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            hz("s2_s", 1'b1); nxt();
        end
        hz("s2_go", 1'b0); nxt();
        // Immediate operand is not a read
        prod(4'd5, 1'b0); nxt();
        cons(4'd1, 4'd5, 1'b0); hz("imm", 1'b0); nxt();
        idle();
        for (int i = 0; i < 3; i++) nxt();
        // Freeze holds shadow and counter
        prod(4'd7, 1'b0); nxt();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            hz("frz_s", 1'b1); nxt();
        end
        chk_cnt("frz_cnt");
        cons(4'd7, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            hz("frz_rel", 1'b1); nxt();
        end
        hz("frz_go", 1'b0);
        chk_cnt("frz_cnt2");
        nxt();
        // Flush wins and allocates nothing
        prod(4'd8, 1'b0); nxt();
        drive(1'b1, 1'b1, 1'b0, 4'd9, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1);
        hz("fl_hz", 1'b0); nxt();
        cons(4'd9, 4'd0, 1'b0); hz("fl_noalloc", 1'b0); nxt();
        cons(4'd8, 4'd0, 1'b0); hz("fl_w", 1'b1); nxt();
        hz("fl_wdone", 1'b0); nxt();
        // Stores never allocate but are consumers
        drive(1'b1, 1'b0, 1'b0, 4'd10, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        hz("st_p", 1'b0); nxt();
        cons(4'd10, 4'd0, 1'b0); hz("st_noalloc", 1'b0); nxt();
        prod(4'd11, 1'b0); nxt();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd11, 1'b1, 1'b0, 1'b0);
        hz("st_cons", 1'b1); nxt();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd11, 4'd0, 1'b0, 1'b0, 1'b0);
        hz("inv", 1'b0); nxt();
        idle();
        for (int i = 0; i < 2; i++) nxt();
        chk_cnt("mid_cnt");
        // Saturation of the narrow counter
        for (int i = 0; i < 2; i++) begin
            prod(4'd14, 1'b1); hz("sat_p", 1'b0); nxt();
            cons(4'd14, 4'd0, 1'b0);
            for (int j = 0; j < 3; j++) begin
                hz("sat_c", 1'b1); nxt();
            end
        end
        idle(); @(negedge clk);
        chk_cnt("sat_cnt");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
